// File: rtl/id_ex_queue.sv
// Decode-to-execute buffer: DEPTH-entry FIFO of decoded bundles with valid/ready on both sides,
// hold/flush control and a pending-destination mask. Optional zero-latency path: ID_EX_BYPASS_EN.
module id_ex_queue #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    input  logic             hold,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic [CNT_W-1:0] count,
    output logic [31:0]      pend_mask
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [4:0]       rd_mem   [DEPTH];
    logic [DEPTH-1:0] rw_mem_reg;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic head_valid;
    logic bypass_take;
    logic push;
    logic pop;

    assign head_valid = (count_reg != '0);
    assign in_ready   = (count_reg != CNT_W'(DEPTH)) && !hold;

`ifdef ID_EX_BYPASS_EN
    // An empty buffer hands the incoming bundle straight to execute.
    assign bypass_take = !head_valid && in_valid && !hold && !flush;
`else
    assign bypass_take = 1'b0;
`endif

    // A bypassed bundle that execute accepts immediately never touches storage.
    assign push = in_valid && in_ready && !flush && !(bypass_take && out_ready);
    assign pop  = head_valid && out_ready && !hold && !flush;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (!hold) begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Write-enable bits are reset so stale entries never look like pending writers.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            rw_mem_reg <= '0;
        end else if (push) begin
            rw_mem_reg[wr_ptr_reg] <= in_regwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= in_data;
            rd_mem[wr_ptr_reg]   <= in_rd;
        end
    end

    always_comb begin
        out_valid    = head_valid || bypass_take;
        out_data     = '0;
        out_rd       = '0;
        out_regwrite = 1'b0;
        if (head_valid) begin
            out_data     = data_mem[rd_ptr_reg];
            out_rd       = rd_mem[rd_ptr_reg];
            out_regwrite = rw_mem_reg[rd_ptr_reg];
        end else if (bypass_take) begin
            out_data     = in_data;
            out_rd       = in_rd;
            out_regwrite = in_regwrite;
        end
    end

    // Entry gi is live when its distance from the head is below the occupancy.
    logic [31:0] entry_mask [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
        logic [PTR_W-1:0] offset;
        logic             live;
        assign offset = PTR_W'(gi) - rd_ptr_reg;
        assign live   = (CNT_W'(offset) < count_reg) && rw_mem_reg[gi];
        assign entry_mask[gi] = live ? (32'd1 << rd_mem[gi]) : 32'd0;
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_mask = pend_mask | entry_mask[i];
        end
        pend_mask[0] = 1'b0;
    end

    assign count = count_reg;

endmodule

// File: doc/id_ex_queue.md
# id_ex_queue

Parametrised decode-to-execute pipeline buffer. It replaces the fixed single-register ID/EX latch with a DEPTH-entry FIFO of packed decoded-control bundles, using a valid/ready handshake on both sides. A global hold freezes the buffer, and a flush squashes every entry after a taken branch or trap. The block also exports a pending-destination scoreboard mask that the hazard unit uses to stall dependent instructions.

## Interface
Parameters:
- WIDTH, 128: payload bits per entry (packed alusel/memread/imm/etc. bundle).
- DEPTH, 2: number of entries; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents a bundle.
- in_ready  out  1  buffer can accept a bundle this cycle.
- in_data  in  WIDTH  decoded bundle.
- in_rd  in  5  destination register of the bundle.
- in_regwrite  in  1  bundle writes in_rd.
- hold  in  1  global freeze (debug, memory hold, or FPU stall).
- flush  in  1  squash all entries (branch taken or trap).
- out_valid  out  1  head entry is valid toward execute.
- out_ready  in  1  execute consumes the head this cycle.
- out_data  out  WIDTH  head bundle; all zeros when empty.
- out_rd  out  5  head destination register; 0 when empty.
- out_regwrite  out  1  head write enable; 0 when empty.
- count  out  CNT_W  occupancy, 0 to DEPTH.
- pend_mask  out  32  bit r is set if any stored entry has regwrite=1 and rd=r, with r not 0.

## Operation
- Storage: DEPTH entries, each holding {data, rd, regwrite}, plus wr_ptr, rd_ptr and count.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- in_ready = (count != DEPTH) and not hold. It does not depend on out_ready, so there is no pass-through when full.
- push = in_valid and in_ready and not flush.
  - Writes entry[wr_ptr] and increments wr_ptr.
- pop = out_valid and out_ready and not hold and not flush.
  - Increments rd_ptr.
- Count update:
  - push and pop together: count unchanged.
  - push only: count + 1.
  - pop only: count - 1.
- out_valid = (count != 0).
- When out_valid = 1, out_data/out_rd/out_regwrite show entry[rd_ptr].
- When out_valid = 0, out_data/out_rd/out_regwrite are forced to 0. This is the bubble: execute sees a NOP with regwrite=0 and memread=0.
- Priority order: reset, then flush, then hold, then push/pop.
  - flush sets count=0, wr_ptr=0, rd_ptr=0 and drops any same-cycle push. A flush asserted while hold is high still clears the buffer.
  - hold with no flush keeps every register unchanged, blocks push and pop, and keeps outputs at their current values.
- pend_mask:
  - Combinational OR over entries i where i is within [rd_ptr, rd_ptr+count) modulo DEPTH and regwrite[i] is set.
  - Bit 0 is always 0.
  - Entry contents outside the occupied range are ignored, whatever their stale value.
- Data RAM entries are not cleared on flush. Only the pointers and count reset.

## Timing
- Reset (Rst=0, asynchronous) sets count=0, wr_ptr=0, rd_ptr=0 and entry regwrite bits = 0. Resulting output values:
  - out_valid=0, out_data=0, out_rd=0, out_regwrite=0
  - count=0, pend_mask=0
  - in_ready=1 (if hold=0)
- Deassertion of reset is released synchronously by the existing reset synchroniser; the block needs no internal synchroniser.
- Latency: an accepted push is visible at out_* and in pend_mask on the next rising edge (1 cycle).
- Throughput: one push and one pop per cycle at any occupancy below DEPTH.
- Full (count = DEPTH): in_ready=0 even if out_ready=1. The pop frees a slot for the following cycle.
- Empty with out_ready=1: no pop, and count does not underflow.
- flush and push in the same cycle: the next cycle shows count=0 and out_valid=0.

## Configuration
- ID_EX_BYPASS_EN defined:
  - When count=0, in_valid=1, hold=0 and flush=0, out_* present in_data/in_rd/in_regwrite combinationally and out_valid=1.
  - If out_ready=1 in that cycle, the bundle is consumed with no write (0-cycle latency) and count stays 0.
  - If out_ready=0, the bundle is pushed normally.
  - pend_mask still covers stored entries only.
- ID_EX_BYPASS_EN undefined: every bundle passes through storage, giving a fixed 1-cycle latency.

## Test plan
- Reset: drive Rst=0 mid-traffic with count=2. Outputs go to 0 immediately (before the next clock edge), and after release in_ready=1 and count=0.
- Fill and drain (DEPTH=4, out_ready=0): push bundles 0xA1..0xA4 with rd=1..4. Expect count=4, in_ready=0, pend_mask=0x0000001E. Then set out_ready=1: out_data must pop A1, A2, A3, A4 on consecutive cycles.
- Wrap-around: 10 continuous push+pop cycles at count=1 with incrementing data. Output order is preserved, count stays 1, and the pointers wrap past DEPTH.
- Flush priority: count=3 and hold=1, then assert flush and in_valid together. The next cycle has count=0, out_valid=0, out_data=0 and pend_mask=0.
- Hold: count=2 with hold=1 for 5 cycles while in_valid=1 and out_ready=1. count, out_data and pend_mask stay unchanged and in_ready=0.
- Bypass (ID_EX_BYPASS_EN only): buffer empty, push 0x55 with out_ready=1. out_data=0x55 in the same cycle and count stays 0. Without the macro, out_data=0x55 appears one cycle later.
